// File: rtl/transform_ctrl_pkg.sv
// Shared types for the 4x4 transform sequencer: state encoding, DC block codes,
// the strobe bundle, and the Moore decode used to build registered outputs.
package transform_ctrl_pkg;

    typedef enum logic [2:0] {
        TC_IDLE   = 3'd0,
        TC_DCONLY = 3'd1,
        TC_IQ     = 3'd2,
        TC_PASS1  = 3'd3,
        TC_PASS2  = 3'd4,
        TC_HOLD   = 3'd5
    } tc_state_e;

    localparam logic [2:0] BT_LUMA16_DC = 3'd1;
    localparam logic [2:0] BT_DC5       = 3'd5;

    typedef struct packed {
        logic       ac_all_0_wr;
        logic       iq_wr;
        logic       dht_wr;
        logic       idct_wr;
        logic       wr_col;
        logic [1:0] wr_idx;
        logic       rd;
        logic       rd_col;
        logic [1:0] rd_idx;
        logic       dht_mode;
        logic       busy;
        logic       valid;
    } tc_out_t;

    function automatic logic is_dc_type(input logic [2:0] bt);
        return (bt == BT_LUMA16_DC) || (bt == BT_DC5);
    endfunction

    function automatic tc_out_t decode(input tc_state_e st, input logic [1:0] cnt, input logic dc);
        tc_out_t o;
        o          = '0;
        o.busy     = (st != TC_IDLE);
        o.dht_mode = o.busy && dc;
        case (st)
            TC_DCONLY: o.ac_all_0_wr = 1'b1;
            TC_IQ: begin
                o.iq_wr  = 1'b1;
                o.wr_idx = cnt;
            end
            TC_PASS1, TC_PASS2: begin
                // Read and write the same line: the bank read is combinational.
                o.rd      = 1'b1;
                o.rd_col  = (st == TC_PASS1);
                o.wr_col  = (st == TC_PASS1);
                o.rd_idx  = cnt;
                o.wr_idx  = cnt;
                o.dht_wr  = dc;
                o.idct_wr = !dc;
            end
            TC_HOLD: o.valid = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/transform_ctrl_if.sv
// Control/strobe bundle between the transform sequencer and its neighbours.
// master = sequencer side, slave = front end / bank / reconstruction side.
interface transform_ctrl_if;
    logic       ena;
    logic       start;
    logic [2:0] block_type;
    logic       ac_all_0;
    logic       ack;
    logic       AC_all_0_wr;
    logic       IQ_wr;
    logic       DHT_wr;
    logic       IDCT_wr;
    logic       wr_col;
    logic [1:0] wr_idx;
    logic       rd;
    logic       rd_col;
    logic [1:0] rd_idx;
    logic       dht_mode;
    logic       busy;
    logic       valid;

    modport master (
        input  ena, start, block_type, ac_all_0, ack,
        output AC_all_0_wr, IQ_wr, DHT_wr, IDCT_wr, wr_col, wr_idx,
               rd, rd_col, rd_idx, dht_mode, busy, valid
    );

    modport slave (
        output ena, start, block_type, ac_all_0, ack,
        input  AC_all_0_wr, IQ_wr, DHT_wr, IDCT_wr, wr_col, wr_idx,
               rd, rd_col, rd_idx, dht_mode, busy, valid
    );
endinterface

// File: rtl/transform_ctrl.sv
// Sequencer for one 4x4 transform block: IQ load, column pass, row pass, hold.
// Optional DC-only shortcut enabled by defining TRANSFORM_CTRL_DC_SHORTCUT_EN.
module transform_ctrl
    import transform_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    transform_ctrl_if.master bus
);

    tc_state_e  state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic [2:0] bt_q, bt_d;
    tc_out_t    out_q, out_d;
    logic       shortcut;
    logic       accept;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bt_d     = bt_q;
        shortcut = 1'b0;
`ifdef TRANSFORM_CTRL_DC_SHORTCUT_EN
        shortcut = bus.ac_all_0 && !is_dc_type(bus.block_type);
`endif
        // HOLD+ack+start re-enters directly so back-to-back blocks have no bubble.
        accept = bus.ena && bus.start &&
                 ((state_q == TC_IDLE) || ((state_q == TC_HOLD) && bus.ack));
        if (accept) begin
            bt_d    = bus.block_type;
            cnt_d   = 2'd0;
            state_d = shortcut ? TC_DCONLY : TC_IQ;
        end else if (bus.ena) begin
            case (state_q)
                TC_IDLE:   ;
                TC_DCONLY: state_d = TC_HOLD;
                TC_IQ: begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = TC_PASS1;
                end
                TC_PASS1: begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = TC_PASS2;
                end
                TC_PASS2: begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = TC_HOLD;
                end
                TC_HOLD: if (bus.ack) state_d = TC_IDLE;
                default: state_d = TC_IDLE;
            endcase
        end
        // Decode the next state so strobes come out of flops aligned with the state.
        out_d = decode(state_d, cnt_d, is_dc_type(bt_d));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TC_IDLE;
            cnt_q   <= 2'd0;
            bt_q    <= 3'd0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bt_q    <= bt_d;
            out_q   <= out_d;
        end
    end

    assign bus.AC_all_0_wr = out_q.ac_all_0_wr;
    assign bus.IQ_wr       = out_q.iq_wr;
    assign bus.DHT_wr      = out_q.dht_wr;
    assign bus.IDCT_wr     = out_q.idct_wr;
    assign bus.wr_col      = out_q.wr_col;
    assign bus.wr_idx      = out_q.wr_idx;
    assign bus.rd          = out_q.rd;
    assign bus.rd_col      = out_q.rd_col;
    assign bus.rd_idx      = out_q.rd_idx;
    assign bus.dht_mode    = out_q.dht_mode;
    assign bus.busy        = out_q.busy;
    assign bus.valid       = out_q.valid;

endmodule
